// File: rtl/lcd_bus_receiver.sv
// HD44780-style 8-bit character-LCD bus responder with a 2x16 DDRAM image.
// Decodes driver strobes, models busy timing, answers status/data reads and serves a renderer port.
module lcd_bus_receiver #(
  parameter int MIN_PW    = 4,
  parameter int BUSY_CYC  = 2000,
  parameter int BUSY_LONG = 76000,
  parameter int CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_index,
  output logic [7:0] rd_char,
  output logic [4:0] cursor_index,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       cmd_dropped,
  output logic       addr_err
);

  localparam int PW_W = $clog2(MIN_PW + 1);
  localparam logic [PW_W-1:0]  PW_MAX  = PW_W'(MIN_PW);
  localparam logic [CNT_W-1:0] CYC_LD  = CNT_W'(BUSY_CYC);
  localparam logic [CNT_W-1:0] LONG_LD = CNT_W'(BUSY_LONG);

  typedef enum logic [1:0] {S_CLEAR, S_READY, S_BUSY} state_t;

  // Two-flop synchronizers for the asynchronous bus
  logic       e_m_q, e_s_q, rs_m_q, rs_s_q, rw_m_q, rw_s_q;
  logic [7:0] d_m_q, d_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_m_q  <= 1'b0;
      e_s_q  <= 1'b0;
      rs_m_q <= 1'b0;
      rs_s_q <= 1'b0;
      rw_m_q <= 1'b0;
      rw_s_q <= 1'b0;
      d_m_q  <= '0;
      d_s_q  <= '0;
    end else begin
      e_m_q  <= lcd_e;
      e_s_q  <= e_m_q;
      rs_m_q <= lcd_rs;
      rs_s_q <= rs_m_q;
      rw_m_q <= lcd_rw;
      rw_s_q <= rw_m_q;
      d_m_q  <= lcd_data_in;
      d_s_q  <= d_m_q;
    end
  end

  logic [PW_W-1:0] hcnt_q, hcnt_d;
  logic            lat_rs_q, lat_rs_d, lat_rw_q, lat_rw_d;
  logic [7:0]      lat_d_q, lat_d_d;
  logic            strobe;

  always_comb begin
    hcnt_d   = '0;
    lat_rs_d = lat_rs_q;
    lat_rw_d = lat_rw_q;
    lat_d_d  = lat_d_q;
    if (e_s_q) begin
      hcnt_d   = (hcnt_q == PW_MAX) ? hcnt_q : hcnt_q + PW_W'(1);
      lat_rs_d = rs_s_q;
      lat_rw_d = rw_s_q;
      lat_d_d  = d_s_q;
    end
  end

  // hcnt_q is non-zero only if e_s was high last cycle, so this is a qualified falling edge
  assign strobe = ~e_s_q & (hcnt_q == PW_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q   <= '0;
      lat_rs_q <= 1'b0;
      lat_rw_q <= 1'b0;
      lat_d_q  <= '0;
    end else begin
      hcnt_q   <= hcnt_d;
      lat_rs_q <= lat_rs_d;
      lat_rw_q <= lat_rw_d;
      lat_d_q  <= lat_d_d;
    end
  end

  function automatic logic [4:0] step(input logic [4:0] idx, input logic inc);
    return inc ? idx + 5'd1 : idx - 5'd1;
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cursor_q, cursor_d;
  logic             id_q, id_d;
  logic             disp_q, disp_d, curs_q, curs_d, blink_q, blink_d;
  logic             drop_q, drop_d, aerr_q, aerr_d;
  logic             ram_we;
  logic [4:0]       ram_waddr;
  logic [7:0]       ram_wdata;
  logic [6:0]       ddram_a;

  assign ddram_a = lat_d_q[6:0];

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    cursor_d  = cursor_q;
    id_d      = id_q;
    disp_d    = disp_q;
    curs_d    = curs_q;
    blink_d   = blink_q;
    drop_d    = 1'b0;
    aerr_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cursor_q;
    ram_wdata = lat_d_q;

    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = fill_q;
        ram_wdata = 8'h20;
        fill_d    = fill_q + 5'd1;
        if (fill_q == 5'd31) begin
          state_d = S_BUSY;
          cnt_d   = LONG_LD;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase

    if (strobe) begin
      if (!lat_rw_q) begin
        if (state_q != S_READY) begin
          drop_d = 1'b1;
        end else begin
          state_d = S_BUSY;
          cnt_d   = CYC_LD;
          if (lat_rs_q) begin
            ram_we    = 1'b1;
            ram_waddr = cursor_q;
            ram_wdata = lat_d_q;
            cursor_d  = step(cursor_q, id_q);
          end else begin
            casez (lat_d_q)
              8'b1???????: begin
                if (ddram_a[6:4] == 3'b000)      cursor_d = {1'b0, ddram_a[3:0]};
                else if (ddram_a[6:4] == 3'b100) cursor_d = {1'b1, ddram_a[3:0]};
                else                             aerr_d   = 1'b1;
              end
              8'b0001????: if (!lat_d_q[3]) cursor_d = step(cursor_q, lat_d_q[2]);
              8'b00001???: begin
                disp_d  = lat_d_q[2];
                curs_d  = lat_d_q[1];
                blink_d = lat_d_q[0];
              end
              8'b000001??: id_d = lat_d_q[1];
              8'b0000001?: begin
                cursor_d = '0;
                cnt_d    = LONG_LD;
              end
              8'b00000001: begin
                cursor_d = '0;
                id_d     = 1'b1;
                fill_d   = '0;
                state_d  = S_CLEAR;
              end
              default: ;  // function set, CGRAM address, 0x00: accepted without effect
            endcase
          end
        end
      end else if (lat_rs_q) begin
        if (state_q == S_READY) cursor_d = step(cursor_q, id_q);
        else                    drop_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      fill_q   <= '0;
      cnt_q    <= '0;
      cursor_q <= '0;
      id_q     <= 1'b1;
      disp_q   <= 1'b0;
      curs_q   <= 1'b0;
      blink_q  <= 1'b0;
      drop_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      id_q     <= id_d;
      disp_q   <= disp_d;
      curs_q   <= curs_d;
      blink_q  <= blink_d;
      drop_q   <= drop_d;
      aerr_q   <= aerr_d;
    end
  end

  logic [7:0] ddram [32];

  always_ff @(posedge clk) begin
    if (ram_we) ddram[ram_waddr] <= ram_wdata;
  end

  logic [7:0] rd_char_q, rd_char_d, dout_q, dout_d, status;

  // Status byte carries the HD44780 address form: line 2 sits at 0x40
  assign status = {busy, cursor_q[4], 2'b00, cursor_q[3:0]};

  always_comb begin
    rd_char_d = ddram[rd_index];
    dout_d    = dout_q;
    if (e_s_q && rw_s_q) dout_d = rs_s_q ? ddram[cursor_q] : status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_char_q <= '0;
      dout_q    <= '0;
    end else begin
      rd_char_q <= rd_char_d;
      dout_q    <= dout_d;
    end
  end

  assign busy         = (state_q != S_READY);
  assign lcd_data_oe  = e_s_q & rw_s_q;
  assign lcd_data_out = dout_q;
  assign rd_char      = rd_char_q;
  assign cursor_index = cursor_q;
  assign disp_on      = disp_q;
  assign cursor_on    = curs_q;
  assign blink_on     = blink_q;
  assign cmd_dropped  = drop_q;
  assign addr_err     = aerr_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed testbench for lcd_bus_receiver with shortened busy times.
// Drives bus transfers on the falling clock edge and compares against hand-computed values.
module tb_lcd_bus_receiver;

  localparam int MIN_PW    = 4;
  localparam int BUSY_CYC  = 40;
  localparam int BUSY_LONG = 300;
  localparam int CNT_W     = 17;
  localparam int BUDGET    = 2 * BUSY_LONG + 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data_in, lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] rd_index;
  logic [7:0] rd_char;
  logic [4:0] cursor_index;
  logic       disp_on, cursor_on, blink_on, busy, cmd_dropped, addr_err;

  lcd_bus_receiver #(
    .MIN_PW(MIN_PW), .BUSY_CYC(BUSY_CYC), .BUSY_LONG(BUSY_LONG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .rd_index(rd_index), .rd_char(rd_char), .cursor_index(cursor_index),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy),
    .cmd_dropped(cmd_dropped), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int drop_seen = 0;
  int aerr_seen = 0;

  always @(negedge clk) begin
    if (cmd_dropped) drop_seen++;
    if (addr_err) aerr_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d, input int width);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = rw;
    lcd_data_in = d;
    lcd_e = 1'b1;
    repeat (width) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] val, output logic oe);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = 1'b1;
    lcd_e = 1'b1;
    repeat (6) @(negedge clk);
    val = lcd_data_out;
    oe = lcd_data_oe;
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < BUDGET && busy; i++) @(negedge clk);
    check_val("ready_within_budget", busy, 0);
  endtask

  task automatic write_cmd(input logic [7:0] d);
    bus_xfer(1'b0, 1'b0, d, 6);
    wait_ready();
  endtask

  task automatic write_data(input logic [7:0] d);
    bus_xfer(1'b1, 1'b0, d, 6);
    wait_ready();
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic peek(input logic [4:0] idx, output logic [7:0] val);
    @(negedge clk);
    rd_index = idx;
    @(negedge clk);
    val = rd_char;
  endtask

  logic [7:0] v;
  logic       oe;
  int         n;

  initial begin
    rst = 1'b1;
    lcd_e = 1'b0;
    lcd_rs = 1'b0;
    lcd_rw = 1'b0;
    lcd_data_in = 8'h00;
    rd_index = 5'd0;
    repeat (3) @(negedge clk);

    check_val("rst_busy", busy, 1);
    check_val("rst_cursor", cursor_index, 0);
    check_val("rst_flags", {disp_on, cursor_on, blink_on}, 0);
    check_val("rst_oe", lcd_data_oe, 0);
    check_val("rst_dout", lcd_data_out, 0);
    check_val("rst_rd_char", rd_char, 0);
    check_val("rst_pulses", {cmd_dropped, addr_err}, 0);

    rst = 1'b0;
    measure_busy(n);
    check_val("init_busy_len", n, 32 + BUSY_LONG);
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      check_val($sformatf("blank[%0d]", i), v, 8'h20);
    end

    bus_read(1'b0, v, oe);
    check_val("status_ready", v, 8'h00);
    check_val("status_oe", oe, 1);

    drop_seen = 0;
    bus_xfer(1'b0, 1'b0, 8'h38, 6);
    bus_read(1'b0, v, oe);
    check_val("status_busy", v, 8'h80);
    check_val("status_read_not_dropped", drop_seen, 0);
    wait_ready();

    write_cmd(8'h0C);
    write_cmd(8'h06);
    write_data(8'h41);
    write_data(8'h42);
    check_val("flags_0c", {disp_on, cursor_on, blink_on}, 3'b100);
    peek(5'd0, v); check_val("ddram0_A", v, 8'h41);
    peek(5'd1, v); check_val("ddram1_B", v, 8'h42);
    check_val("cursor_after_AB", cursor_index, 2);

    write_cmd(8'h8F);
    write_data(8'h5A);
    write_data(8'h5B);
    peek(5'd15, v); check_val("ddram15", v, 8'h5A);
    peek(5'd16, v); check_val("ddram16", v, 8'h5B);
    check_val("cursor_15_to_16", cursor_index, 17);

    write_cmd(8'hCF);
    write_data(8'h31);
    peek(5'd31, v); check_val("ddram31", v, 8'h31);
    check_val("cursor_31_to_0", cursor_index, 0);

    write_cmd(8'h04);
    write_cmd(8'h80);
    write_data(8'h44);
    peek(5'd0, v); check_val("ddram0_dec", v, 8'h44);
    check_val("cursor_0_to_31", cursor_index, 31);
    bus_read(1'b0, v, oe);
    check_val("status_line2", v, 8'h4F);

    aerr_seen = 0;
    bus_xfer(1'b0, 1'b0, 8'h95, 6);
    check_val("addr_err_pulse", aerr_seen, 1);
    check_val("addr_err_busy", busy, 1);
    wait_ready();
    check_val("addr_err_cursor", cursor_index, 31);

    bus_read(1'b1, v, oe);
    check_val("data_read", v, 8'h31);
    check_val("data_read_oe", oe, 1);
    check_val("data_read_cursor", cursor_index, 30);

    write_cmd(8'h14);
    check_val("shift_right", cursor_index, 31);
    write_cmd(8'h10);
    check_val("shift_left", cursor_index, 30);
    write_cmd(8'h0F);
    check_val("flags_0f", {disp_on, cursor_on, blink_on}, 3'b111);
    write_cmd(8'h02);
    check_val("home_cursor", cursor_index, 0);
    peek(5'd0, v); check_val("home_keeps_ddram", v, 8'h44);

    drop_seen = 0;
    bus_xfer(1'b1, 1'b0, 8'h77, 2);
    peek(5'd0, v); check_val("short_pulse_ddram", v, 8'h44);
    check_val("short_pulse_cursor", cursor_index, 0);
    check_val("short_pulse_busy", busy, 0);
    bus_xfer(1'b0, 1'b0, 8'h06, 3);
    check_val("pw3_ignored", busy, 0);
    bus_xfer(1'b0, 1'b0, 8'h06, 4);
    check_val("pw4_accepted", busy, 1);
    bus_xfer(1'b1, 1'b0, 8'h55, 6);
    check_val("drop_pulse", drop_seen, 1);
    wait_ready();
    peek(5'd0, v); check_val("drop_ddram", v, 8'h44);
    check_val("drop_cursor", cursor_index, 0);
    write_data(8'h66);
    peek(5'd0, v); check_val("write_after_drop", v, 8'h66);
    check_val("id_inc_after_06", cursor_index, 1);
    write_data(8'h67);
    write_data(8'h68);

    bus_xfer(1'b0, 1'b0, 8'h01, 6);
    repeat (9) @(negedge clk);
    check_val("clear_busy", busy, 1);
    check_val("clear_cursor", cursor_index, 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("midclear_rst_busy", busy, 1);
    check_val("midclear_rst_flags", {disp_on, cursor_on, blink_on}, 0);
    rst = 1'b0;
    measure_busy(n);
    check_val("reclear_busy_len", n, 32 + BUSY_LONG);
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      check_val($sformatf("reclear[%0d]", i), v, 8'h20);
    end
    check_val("reclear_cursor", cursor_index, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
